// File: rtl/ticket_vendor_param.sv
// Parametrised transit ticket vendor: accumulates $10/$20 bills against PRICE_UNITS,
// dispenses a ticket, pays change one $10 bill per cycle, and returns credit on cancel/timeout.
module ticket_vendor_param #(
  parameter int PRICE_UNITS    = 4,
  parameter int CREDIT_W       = 4,
  parameter bit MAKE_CHANGE    = 1'b1,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                Clock,
  input  logic                Clear_n,
  input  logic                Ten,
  input  logic                Twenty,
  input  logic                Cancel,
  output logic                Ready,
  output logic                Bill,
  output logic                Dispense,
  output logic                Return,
  output logic                ChangeTen,
  output logic [CREDIT_W-1:0] Credit
);

  localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_UNITS);
  localparam int IDLE_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int IDLE_W   = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MAX);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_RDY    = 3'd0,
    S_ACCUM  = 3'd1,
    S_DISP   = 3'd2,
    S_CHANGE = 3'd3,
    S_RTN    = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [CREDIT_W-1:0] deposit;
  logic [CREDIT_W-1:0] sum;
  logic [IDLE_W-1:0]   idle;
  logic [IDLE_W-1:0]   idle_nxt;
  logic                timed_out;

  // Ten and Twenty together are both credited, so the deposit is simply {Twenty, Ten}.
  assign deposit   = CREDIT_W'({Twenty, Ten});
  assign sum       = credit + deposit;
  assign timed_out = TIMEOUT_EN && (idle == IDLE_LAST);
  assign Credit    = credit;

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    idle_nxt   = '0;
    unique case (state)
      S_RDY, S_ACCUM: begin
        // Cancel only matters once credit is held; bills in the cancel cycle are dropped.
        if (state == S_ACCUM && Cancel) begin
          state_nxt = S_RTN;
        end else if (deposit != '0) begin
          if (sum < PRICE) begin
            state_nxt  = S_ACCUM;
            credit_nxt = sum;
          end else if (sum == PRICE) begin
            state_nxt  = S_DISP;
            credit_nxt = '0;
          end else if (MAKE_CHANGE) begin
            state_nxt  = S_DISP;
            credit_nxt = sum - PRICE;
          end else begin
            state_nxt  = S_RTN;
            credit_nxt = sum;
          end
        end else if (state == S_ACCUM) begin
          if (timed_out) state_nxt = S_RTN;
          else           idle_nxt  = idle + 1'b1;
        end
      end
      S_DISP: begin
        state_nxt = (credit == '0) ? S_RDY : S_CHANGE;
      end
      S_CHANGE: begin
        credit_nxt = credit - 1'b1;
        if (credit <= CREDIT_W'(1)) begin
          state_nxt  = S_RDY;
          credit_nxt = '0;
        end
      end
      S_RTN: begin
        state_nxt  = S_RDY;
        credit_nxt = '0;
      end
      default: begin
        state_nxt  = S_RDY;
        credit_nxt = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      state     <= S_RDY;
      credit    <= '0;
      idle      <= '0;
      Ready     <= 1'b1;
      Bill      <= 1'b0;
      Dispense  <= 1'b0;
      Return    <= 1'b0;
      ChangeTen <= 1'b0;
    end else begin
      state     <= state_nxt;
      credit    <= credit_nxt;
      idle      <= idle_nxt;
      Ready     <= (state_nxt == S_RDY);
      Bill      <= (state_nxt == S_ACCUM);
      Dispense  <= (state_nxt == S_DISP);
      Return    <= (state_nxt == S_RTN);
      ChangeTen <= (state_nxt == S_CHANGE);
    end
  end

endmodule
